spi_master_arbiter: RTL and testbench
=====================================

# spi_master_arbiter

Shares a single SPI master shift engine among NREQ requesters, each owning one slave select line, and sequences every byte transfer. It sits on the master side of the SPI bus, driving SCLK/MOSI/CS into slaves such as the existing SPI slave block. Requests are served by round-robin arbitration. Each grant performs exactly one 8-bit, MSB-first, full-duplex transfer in the configured CPOL/CPHA mode.

## Interface
- NREQ, 4: number of requesters and CS lines (2..8).
- MODE, 2'd2: {CPOL, CPHA}.
- HALF_DIV, 2: CLK cycles per SCLK half-period (≥1).
- CS_GAP, 2: minimum CLK cycles CS stays all-high between transfers (≥1).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  NREQ  per-requester transfer request; level, held until matching done.
- tx_data  in  8*NREQ  byte for requester i is on bits [8i+7:8i]; sampled in the grant cycle.
- grant  out  NREQ  one-hot; high for the whole transfer.
- done  out  NREQ  one-hot, 1-cycle pulse at transfer end.
- rx_data  out  8  received byte; valid with done, held until next done.
- busy  out  1  high from grant through end of gap.
- SCLK  out  1  SPI clock; idles at CPOL.
- MOSI  out  1  master data out.
- MISO  in  1  slave data in; same CLK domain.
- CS  out  NREQ  active-low selects; CS[i] low only while grant[i].

## Operation
- States: IDLE → XFER → GAP → IDLE or XFER.
- IDLE: if any req is high, pick a winner round-robin, starting the search at the index after the last served requester. After reset, the search starts at 0.
- IDLE, grant: winner's tx_data is latched into the shift register, grant[i]=1, CS[i]=0, busy=1, and the engine enters XFER.
- XFER: SCLK toggles every HALF_DIV cycles, giving 16 edges. Odd edges are leading, even edges are trailing.
  - CPHA=0: MOSI = bit7 from the grant cycle. Sample MISO on leading edges. Shift out the next bit on trailing edges (not after edge 16).
  - CPHA=1: drive the next bit on leading edges (bit7 on edge 1). Sample on trailing edges.
- Received bits shift in LSB-side, so the first sampled bit ends up in rx_data[7].
- End of XFER, HALF_DIV cycles after edge 16:
  - CS all high, grant=0, MOSI=0.
  - done[i] pulses; rx_data updates.
  - The engine enters GAP.
- GAP: CS_GAP cycles. Arbitration happens on the last GAP cycle, so a pending req grants immediately after the gap; otherwise the engine returns to IDLE and busy drops.
- Dropping req mid-transfer has no effect: the transfer completes and done still pulses.
- tx_data changes after the grant cycle are ignored.
- When CS is all high, MOSI=0 and SCLK=CPOL.

## Timing
- Reset (reset=0 at a rising edge):
  - grant=0, done=0, rx_data=8'h00, busy=0.
  - CS all 1, SCLK=CPOL, MOSI=0.
  - Round-robin pointer set so requester 0 wins first.
  - Reset dominates every other event. A transfer in progress is aborted with no done pulse.
- req high at edge t while IDLE → grant/CS low registered at edge t+1 (call this cycle G).
- SCLK edge k occurs at G + k·HALF_DIV.
- done pulses and CS rises at G + 17·HALF_DIV. With defaults this is G+34.
- Next grant occurs no earlier than G + 17·HALF_DIV + CS_GAP.
- done and the new grant never coincide.
- Simultaneous requests: exactly one grant. The others wait with no starvation: each waits at most NREQ−1 transfers.

## Test plan
- MODE=2, HALF_DIV=2: req[0] with tx 8'hB3; slave returns 8'h5A.
  - Expect MOSI bits 1,0,1,1,0,0,1,1 and SCLK idle high.
  - Expect done[0] at G+34 with rx_data=8'h5A, then CS[0] high for ≥2 cycles.
- Loopback (MISO=MOSI) for each MODE 0..3 with tx 8'h96.
  - Expect rx_data=8'h96 in every mode.
  - Expect SCLK idle = CPOL.
  - Expect 16 SCLK edges per transfer.
- req[0] and req[2] asserted together after reset, both held for four transfers.
  - Expect grant order 0,2,0,2.
  - Expect no grant to 1 or 3.
  - Expect CS gap of exactly 2 cycles between transfers.
- reset driven low just after SCLK edge 7.
  - Next cycle: CS=4'b1111, SCLK=CPOL, grant=0, busy=0, no done.
  - After reset releases with req[1] held: a fresh full transfer to requester 1.
- req[3] dropped after edge 4; tx_data changed mid-transfer.
  - Transfer completes with the originally latched byte.
  - done[3] pulses once.
  - Afterwards the engine returns to IDLE.

Source files
------------

// File: rtl/spi_master_arbiter_if.sv
// Bus between the shared SPI master engine and its requesters/slaves.
// The master modport is the engine's view; slave is the requester/slave side.
interface spi_master_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] tx_data;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic [7:0]        rx_data;
    logic              busy;
    logic              SCLK;
    logic              MOSI;
    logic              MISO;
    logic [NREQ-1:0]   CS;

    modport master (
        input  req, tx_data, MISO,
        output grant, done, rx_data, busy, SCLK, MOSI, CS
    );

    modport slave (
        output req, tx_data, MISO,
        input  grant, done, rx_data, busy, SCLK, MOSI, CS
    );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one 8-bit SPI master shifter among NREQ requesters.
// A grant runs one full-duplex byte; done pulses 17*HALF_DIV cycles after grant, then CS_GAP idle cycles.
module spi_master_arbiter #(
    parameter int         NREQ     = 4,
    parameter logic [1:0] MODE     = 2'd2,
    parameter int         HALF_DIV = 2,
    parameter int         CS_GAP   = 2
) (
    input  logic                 CLK,
    input  logic                 reset,
    spi_master_arbiter_if.master bus
);
    localparam logic CPOL = MODE[1];
    localparam logic CPHA = MODE[0];
    localparam int   IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int   DW   = $clog2(HALF_DIV + 1);
    localparam int   GW   = $clog2(CS_GAP + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(HALF_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_div;
    logic [4:0]      r_edge;
    logic [GW-1:0]   r_gap;
    logic [7:0]      r_tx;
    logic [7:0]      r_rx;
    logic [7:0]      r_rx_data;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] r_done;
    logic            r_sclk;
    logic            r_mosi;
    logic            r_busy;
    logic [IW-1:0]   r_last;

    logic [IW-1:0]   w_win_idx;
    logic            w_win_vld;
    logic            w_arb;
    logic            w_start;
    logic [7:0]      w_byte;
    logic            w_tick;
    logic [4:0]      w_edge_n;
    logic            w_lead;
    logic            w_end;
    logic            w_shift;
    logic            w_sample;

    // Lowest offset after the last served requester wins; loop runs far-to-near so near overwrites.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (bus.req[(int'(r_last) + k) % NREQ]) begin
                w_win_vld = 1'b1;
                w_win_idx = IW'((int'(r_last) + k) % NREQ);
            end
        end
    end

    assign w_arb    = (r_state == S_IDLE) || ((r_state == S_GAP) && (r_gap == GAP_LAST));
    assign w_start  = w_arb && w_win_vld;
    assign w_byte   = bus.tx_data[int'(w_win_idx)*8 +: 8];
    assign w_tick   = (r_state == S_XFER) && (r_div == DIV_LAST);
    assign w_edge_n = r_edge + 5'd1;
    assign w_lead   = w_edge_n[0];
    assign w_end    = w_tick && (w_edge_n == 5'd17);
    assign w_shift  = w_tick && !w_end && (CPHA ? w_lead : (!w_lead && (w_edge_n != 5'd16)));
    assign w_sample = w_tick && !w_end && (CPHA ? !w_lead : w_lead);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_XFER;
            S_XFER:  if (w_end) w_state_nxt = S_GAP;
            S_GAP:   if (r_gap == GAP_LAST) w_state_nxt = w_start ? S_XFER : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_edge    <= '0;
            r_gap     <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_grant   <= '0;
            r_done    <= '0;
            r_sclk    <= CPOL;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_last    <= IW'(NREQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_done  <= '0;
            if (w_start) begin
                r_grant <= {{(NREQ-1){1'b0}}, 1'b1} << w_win_idx;
                r_last  <= w_win_idx;
                r_busy  <= 1'b1;
                r_div   <= '0;
                r_edge  <= '0;
                r_rx    <= '0;
                // CPHA=0 presents bit7 before the first edge; CPHA=1 drives it on edge 1.
                r_tx    <= CPHA ? w_byte : {w_byte[6:0], 1'b0};
                r_mosi  <= CPHA ? 1'b0 : w_byte[7];
            end else if (r_state == S_XFER) begin
                if (w_tick) begin
                    r_div  <= '0;
                    r_edge <= w_edge_n;
                    if (w_end) begin
                        r_grant   <= '0;
                        r_mosi    <= 1'b0;
                        r_done    <= r_grant;
                        r_rx_data <= r_rx;
                        r_gap     <= '0;
                    end else begin
                        r_sclk <= ~r_sclk;
                    end
                    if (w_shift) begin
                        r_mosi <= r_tx[7];
                        r_tx   <= {r_tx[6:0], 1'b0};
                    end
                    if (w_sample) begin
                        r_rx <= {r_rx[6:0], bus.MISO};
                    end
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end else if (r_state == S_GAP) begin
                if (r_gap == GAP_LAST) begin
                    r_busy <= 1'b0;
                end else begin
                    r_gap <= r_gap + 1'b1;
                end
            end
        end
    end

    assign bus.grant   = r_grant;
    assign bus.done    = r_done;
    assign bus.rx_data = r_rx_data;
    assign bus.busy    = r_busy;
    assign bus.SCLK    = r_sclk;
    assign bus.MOSI    = r_mosi;
    assign bus.CS      = ~r_grant;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench: one arbiter per SPI mode sharing stimulus; mode 2 talks to a byte slave or loops back.
// The others always loop MISO to MOSI.
module tb_spi_master_arbiter;
    localparam int NREQ     = 4;
    localparam int HALF_DIV = 2;
    localparam int CS_GAP   = 2;
    localparam int LIMIT    = 200;

    logic              CLK     = 1'b0;
    logic              reset   = 1'b0;
    logic [NREQ-1:0]   req     = '0;
    logic [8*NREQ-1:0] tx_data = '0;
    logic              lb_en   = 1'b0;
    logic [7:0]        s_byte  = '0;
    logic [7:0]        base    = '0;
    logic [7:0]        n2;
    logic              miso_s;
    int                cyc      = 0;
    int                n_checks = 0;
    int                n_errors = 0;

    logic [3:0][3:0] grant_a, done_a, cs_a;
    logic [3:0][7:0] rx_a, ecnt_a, cap_a;
    logic [3:0]      sclk_a, mosi_a, busy_a;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Mode-2 slave: bit7 ready at CS fall, next bit after each trailing edge.
    always_comb begin
        n2     = ecnt_a[2] - base;
        miso_s = (n2 < 8'd16) ? s_byte[3'd7 - n2[3:1]] : 1'b0;
    end

    for (genvar m = 0; m < 4; m++) begin : g_mode
        spi_master_arbiter_if #(.NREQ(NREQ)) u_if ();
        logic [7:0] ec = '0;
        logic [7:0] cp = '0;

        assign u_if.req     = req;
        assign u_if.tx_data = tx_data;
        assign u_if.MISO    = (m == 2 && !lb_en) ? miso_s : u_if.MOSI;

        spi_master_arbiter #(
            .NREQ(NREQ), .MODE(2'(m)), .HALF_DIV(HALF_DIV), .CS_GAP(CS_GAP)
        ) u_dut (
            .CLK   (CLK),
            .reset (reset),
            .bus   (u_if)
        );

        always @(u_if.SCLK) begin
            if (u_if.CS != 4'hF) begin
                ec = ec + 8'd1;
                if (((ec - base) & 8'd1) == 8'd1) cp = {cp[6:0], u_if.MOSI};
            end
        end

        assign grant_a[m] = u_if.grant;
        assign done_a[m]  = u_if.done;
        assign cs_a[m]    = u_if.CS;
        assign rx_a[m]    = u_if.rx_data;
        assign sclk_a[m]  = u_if.SCLK;
        assign mosi_a[m]  = u_if.MOSI;
        assign busy_a[m]  = u_if.busy;
        assign ecnt_a[m]  = ec;
        assign cap_a[m]   = cp;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_grant(input string tag, output int gc);
        int k = 0;
        while (grant_a[2] == 4'h0 && k < LIMIT) begin
            @(negedge CLK);
            k++;
        end
        gc = cyc;
        check({tag, "_grant_seen"}, 32'(k < LIMIT), 32'd1);
    endtask

    task automatic wait_done(input string tag, output int dc);
        int k = 0;
        while (done_a[2] == 4'h0 && k < LIMIT) begin
            @(negedge CLK);
            k++;
        end
        dc = cyc;
        check({tag, "_done_seen"}, 32'(k < LIMIT), 32'd1);
    endtask

    task automatic wait_edges(input string tag, input logic [7:0] n);
        int k = 0;
        while (8'(ecnt_a[2] - base) < n && k < LIMIT) begin
            @(negedge CLK);
            k++;
        end
        check({tag, "_edges_seen"}, 32'(k < LIMIT), 32'd1);
    endtask

    initial begin
        int         g, d, nd;
        logic [7:0] rxs;
        logic [7:0] e0 [4];
        logic [3:0] rr_exp [4];
        rr_exp = '{4'h1, 4'h4, 4'h1, 4'h4};

        // Reset values
        repeat (3) @(negedge CLK);
        check("rst_grant", 32'(grant_a[2]), 32'h0);
        check("rst_done",  32'(done_a[2]),  32'h0);
        check("rst_rx",    32'(rx_a[2]),    32'h00);
        check("rst_busy",  32'(busy_a[2]),  32'h0);
        check("rst_cs",    32'(cs_a[2]),    32'hF);
        check("rst_mosi",  32'(mosi_a[2]),  32'h0);
        check("rst_sclk",  32'(sclk_a),     32'b1100);
        reset = 1'b1;
        @(negedge CLK);

        // Mode 2 against a slave returning 5A, master sends B3
        base    = ecnt_a[2];
        s_byte  = 8'h5A;
        lb_en   = 1'b0;
        tx_data[7:0] = 8'hB3;
        req     = 4'b0001;
        wait_grant("t1", g);
        check("t1_grant", 32'(grant_a[2]), 32'h1);
        check("t1_cs",    32'(cs_a[2]),    32'hE);
        check("t1_busy",  32'(busy_a[2]),  32'h1);
        check("t1_mosi0", 32'(mosi_a[2]),  32'h1);
        wait_done("t1", d);
        check("t1_lat",   32'(d - g),      32'd34);
        check("t1_done",  32'(done_a[2]),  32'h1);
        check("t1_rx",    32'(rx_a[2]),    32'h5A);
        check("t1_mosi_bits", 32'(cap_a[2]), 32'hB3);
        check("t1_edges", 32'(8'(ecnt_a[2] - base)), 32'd16);
        check("t1_cs_end",    32'(cs_a[2]),    32'hF);
        check("t1_grant_end", 32'(grant_a[2]), 32'h0);
        check("t1_sclk_idle", 32'(sclk_a[2]),  32'h1);
        check("t1_mosi_idle", 32'(mosi_a[2]),  32'h0);
        req = 4'b0000;
        @(negedge CLK);
        check("t1_gap_busy", 32'(busy_a[2]), 32'h1);
        check("t1_gap_cs",   32'(cs_a[2]),   32'hF);
        @(negedge CLK);
        check("t1_idle_busy", 32'(busy_a[2]), 32'h0);
        check("t1_idle_cs",   32'(cs_a[2]),   32'hF);

        // Loopback 96 through all four modes in parallel
        @(negedge CLK);
        lb_en = 1'b1;
        tx_data[15:8] = 8'h96;
        for (int m = 0; m < 4; m++) e0[m] = ecnt_a[m];
        base = ecnt_a[2];
        req  = 4'b0010;
        wait_grant("lb", g);
        wait_done("lb", d);
        check("lb_lat", 32'(d - g), 32'd34);
        for (int m = 0; m < 4; m++) begin
            check($sformatf("lb%0d_rx", m),    32'(rx_a[m]), 32'h96);
            check($sformatf("lb%0d_edges", m), 32'(8'(ecnt_a[m] - e0[m])), 32'd16);
            check($sformatf("lb%0d_sclk", m),  32'(sclk_a[m]), 32'(m >= 2));
        end
        req = 4'b0000;
        repeat (4) @(negedge CLK);

        // Round robin between requesters 0 and 2 after a fresh reset
        reset = 1'b0;
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        tx_data[7:0]   = 8'h11;
        tx_data[23:16] = 8'h33;
        req = 4'b0101;
        d = 0;
        for (int i = 0; i < 4; i++) begin
            wait_grant($sformatf("rr%0d", i), g);
            check($sformatf("rr%0d_grant", i), 32'(grant_a[2]), 32'(rr_exp[i]));
            if (i > 0) check($sformatf("rr%0d_gap", i), 32'(g - d), 32'd2);
            wait_done($sformatf("rr%0d", i), d);
            check($sformatf("rr%0d_done", i), 32'(done_a[2]), 32'(rr_exp[i]));
            check($sformatf("rr%0d_nogrant", i), 32'(grant_a[2]), 32'h0);
            check($sformatf("rr%0d_rx", i), 32'(rx_a[2]), (i % 2 == 0) ? 32'h11 : 32'h33);
        end
        req = 4'b0000;
        repeat (4) @(negedge CLK);

        // Reset just after SCLK edge 7, then a fresh transfer to requester 1
        tx_data[15:8] = 8'hA5;
        base = ecnt_a[2];
        req  = 4'b0010;
        wait_grant("ra", g);
        wait_edges("ra", 8'd7);
        reset = 1'b0;
        @(negedge CLK);
        check("ra_cs",    32'(cs_a[2]),    32'hF);
        check("ra_sclk",  32'(sclk_a[2]),  32'h1);
        check("ra_grant", 32'(grant_a[2]), 32'h0);
        check("ra_busy",  32'(busy_a[2]),  32'h0);
        check("ra_done",  32'(done_a[2]),  32'h0);
        reset = 1'b1;
        @(negedge CLK);
        base = ecnt_a[2];
        wait_grant("ra2", g);
        check("ra2_grant", 32'(grant_a[2]), 32'h2);
        wait_done("ra2", d);
        check("ra2_lat",   32'(d - g),      32'd34);
        check("ra2_rx",    32'(rx_a[2]),    32'hA5);
        check("ra2_edges", 32'(8'(ecnt_a[2] - base)), 32'd16);
        req = 4'b0000;
        repeat (4) @(negedge CLK);

        // req[3] dropped after edge 4 and tx_data changed mid-transfer
        tx_data[31:24] = 8'hC5;
        base = ecnt_a[2];
        req  = 4'b1000;
        wait_grant("dr", g);
        wait_edges("dr", 8'd4);
        req = 4'b0000;
        tx_data[31:24] = 8'h00;
        nd  = 0;
        rxs = 8'h00;
        for (int k = 0; k < 60; k++) begin
            @(negedge CLK);
            if (done_a[2][3]) begin
                nd++;
                rxs = rx_a[2];
            end
        end
        check("dr_done_count", 32'(nd),         32'd1);
        check("dr_rx",         32'(rxs),        32'hC5);
        check("dr_busy",       32'(busy_a[2]),  32'h0);
        check("dr_grant",      32'(grant_a[2]), 32'h0);
        check("dr_cs",         32'(cs_a[2]),    32'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
